// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - oversampling sclk/sdata deserializer with valid/ack word output
//
// Purpose:
//   Receive end of the two-wire sclk/sdata LED link. sclk_in and sdata_in are
//   synchronised into the clki domain and oversampled. Each synchronised
//   rising edge of sclk shifts one sdata bit into the frame, MSB first. A
//   completed WIDTH-bit word is presented on data/valid and held until ack.
//   An idle timeout discards partial frames. A frame that completes while the
//   previous word is still unacknowledged is dropped and flagged as overrun.
//
// Optional feature (macro SERIAL_RX_PARITY_EN):
//   When defined, one even-parity bit follows the WIDTH data bits. A parity
//   mismatch pulses frame_err and the word is not loaded.
//
// Parameters:
//   WIDTH    data bits per frame (>= 2)
//   TIMEOUT  clki cycles without an sclk rise before a partial frame is
//            discarded (>= 4)
//
// Ports:
//   clki       in   system clock
//   rst        in   synchronous reset, active high
//   sclk_in    in   serial clock, asynchronous to clki
//   sdata_in   in   serial data, sampled on the sclk_in rising edge
//   data       out  received word, stable while valid=1
//   valid      out  word available, held until acknowledged
//   ack        in   consumer accepts word, honoured only while valid=1
//   busy       out  frame in progress
//   overrun    out  sticky, a frame completed while valid=1 and ack=0
//   frame_err  out  one-cycle pulse on timeout (or parity error)

module serial_rx #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic             clki,
  input  logic             rst,
  input  logic             sclk_in,
  input  logic             sdata_in,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ack,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int IDLE_W = $clog2(TIMEOUT);

  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;
`endif

  // Synchroniser chain. sdata gets the same two-flop delay as sclk so the
  // bit taken on an edge cycle is the one that was on the wire at the rise.
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic sdata_s1_q, sdata_s2_q;

  logic sclk_rise;
  logic sdata_bit;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic               frame_err_q, frame_err_d;
`ifdef SERIAL_RX_PARITY_EN
  logic               par_err_q, par_err_d;
`endif

  logic in_frame;
  logic load_word;

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sdata_bit = sdata_s2_q;

`ifdef SERIAL_RX_PARITY_EN
  assign in_frame = (state_q == S_SHIFT) || (state_q == S_PARITY);
`else
  assign in_frame = (state_q == S_SHIFT);
`endif

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    load_word   = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_err_d   = par_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (sclk_rise) begin
          shreg_d    = {{(WIDTH-1){1'b0}}, sdata_bit};
          bit_cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
          idle_cnt_d = '0;
          state_d    = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (sclk_rise) begin
          shreg_d    = {shreg_q[WIDTH-2:0], sdata_bit};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          idle_cnt_d = '0;
          if (bit_cnt_d == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_DONE;
`endif
          end
        end
      end

`ifdef SERIAL_RX_PARITY_EN
      S_PARITY: begin
        if (sclk_rise) begin
          // Even parity: data bits plus parity bit must XOR to zero. The error
          // is registered here so frame_err is visible during DONE.
          par_err_d   = ^{shreg_q, sdata_bit};
          frame_err_d = ^{shreg_q, sdata_bit};
          idle_cnt_d  = '0;
          state_d     = S_DONE;
        end
      end
`endif

      S_DONE: begin
`ifdef SERIAL_RX_PARITY_EN
        par_err_d = 1'b0;
        if (!par_err_q) begin
`else
        begin
`endif
          // An ack in this same cycle frees the holding register, so the new
          // word replaces the old one instead of being counted as overrun.
          if (!valid_q || ack) begin
            load_word = 1'b1;
            data_d    = shreg_q;
            valid_d   = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end

        // A rise landing in DONE already belongs to the next frame.
        if (sclk_rise) begin
          shreg_d    = {{(WIDTH-1){1'b0}}, sdata_bit};
          bit_cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
          idle_cnt_d = '0;
          state_d    = S_SHIFT;
        end else begin
          bit_cnt_d  = '0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Idle watchdog only runs mid-frame, so gaps between frames are unbounded.
    if (in_frame && !sclk_rise) begin
      if (idle_cnt_q == IDLE_MAX) begin
        frame_err_d = 1'b1;
        shreg_d     = '0;
        bit_cnt_d   = '0;
        idle_cnt_d  = '0;
        state_d     = S_IDLE;
      end else begin
        idle_cnt_d  = idle_cnt_q + 1'b1;
      end
    end

    // Handshake: a consumed word drops valid and clears the sticky overrun,
    // unless the same cycle reloaded the holding register.
    if (valid_q && ack && !load_word) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_s3_q   <= 1'b0;
      sdata_s1_q  <= 1'b0;
      sdata_s2_q  <= 1'b0;
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      sclk_s1_q   <= sclk_in;
      sclk_s2_q   <= sclk_s1_q;
      sclk_s3_q   <= sclk_s2_q;
      sdata_s1_q  <= sdata_in;
      sdata_s2_q  <= sdata_s1_q;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
`ifdef SERIAL_RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = in_frame;

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - randomized scoreboard bench for serial_rx
`timescale 1ns/1ps
module tb_serial_rx;

  localparam int W  = 8;
  localparam int TO = 64;
`ifdef SERIAL_RX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  localparam int M_PLAIN   = 0;
  localparam int M_LAT     = 1;
  localparam int M_ACKDONE = 2;

  logic         clki     = 1'b0;
  logic         rst      = 1'b1;
  logic         sclk_in  = 1'b0;
  logic         sdata_in = 1'b0;
  logic         ack      = 1'b0;
  logic [W-1:0] data;
  logic         valid, busy, overrun, frame_err;

  serial_rx #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clki      (clki),
    .rst       (rst),
    .sclk_in   (sclk_in),
    .sdata_in  (sdata_in),
    .data      (data),
    .valid     (valid),
    .ack       (ack),
    .busy      (busy),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clki = ~clki;

  int n_pass  = 0;
  int n_total = 0;

  // Scoreboard queues: words the receiver must deliver, and the overrun flag
  // expected at the moment each word is consumed.
  logic [W-1:0] exp_data_q[$];
  logic         exp_ovr_q[$];

  // Abstract model of the output holding register.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  logic         m_ovr   = 1'b0;
  int           fe_exp  = 0;
  int           fe_seen = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clki);
  endtask

  // Frame as transmitted, MSB first; the even-parity bit trails the data.
  function automatic logic [NB-1:0] frame_bits(input logic [W-1:0] w);
`ifdef SERIAL_RX_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  task automatic model_frame(input logic [W-1:0] word, input logic bad, input logic ack_in_done);
    if (bad) begin
      fe_exp++;
    end else if (ack_in_done && m_valid) begin
      exp_ovr_q.push_back(m_ovr);
      exp_data_q.push_back(word);
      m_data = word;
    end else if (!m_valid) begin
      exp_data_q.push_back(word);
      m_data  = word;
      m_valid = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic send_bit(input logic b);
    sdata_in = b;
    tick(3 + int'($urandom_range(0, 3)));
    sclk_in = 1'b1;
    tick(4);
    sclk_in = 1'b0;
  endtask

  task automatic do_ack();
    if (m_valid) begin
      exp_ovr_q.push_back(m_ovr);
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  // Last edge is driven inline so DONE (third negedge after the rise) and
  // the registered output (fourth negedge) can be observed exactly.
  task automatic send_frame(input logic [W-1:0] word, input logic bad_par, input int mode);
    logic [NB-1:0] bits;
    logic          pre_valid;
    bits = frame_bits(word);
`ifdef SERIAL_RX_PARITY_EN
    bits[0] = bits[0] ^ bad_par;
`endif
    pre_valid = m_valid;
    model_frame(word, bad_par, mode == M_ACKDONE);
    for (int i = NB - 1; i >= 1; i--) send_bit(bits[i]);
    if (mode == M_LAT) check1("busy_mid_frame", busy, 1'b1);
    sdata_in = bits[0];
    tick(3 + int'($urandom_range(0, 3)));
    sclk_in = 1'b1;
    tick(3);
    if (mode == M_ACKDONE) ack = 1'b1;
    if (mode == M_LAT) begin
      check1("valid_before_latency", valid, pre_valid);
      check1("busy_in_done", busy, 1'b0);
      check1("frame_err_in_done", frame_err, bad_par);
    end
    tick(1);
    ack = 1'b0;
    if (mode != M_PLAIN) begin
      check1("valid_after_done", valid, m_valid);
      if (m_valid) checkw("data_after_done", data, m_data);
      check1("overrun_after_done", overrun, m_ovr);
    end
    tick(3);
    sclk_in = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check1({tag, "_valid"}, valid, m_valid);
    check1({tag, "_overrun"}, overrun, m_ovr);
    if (m_valid) checkw({tag, "_data"}, data, m_data);
  endtask

  // Monitor: a word is consumed whenever valid and ack are both high.
  initial forever begin
    @(negedge clki);
    #1;
    if (!rst && valid === 1'b1 && ack === 1'b1) begin
      if (exp_data_q.size() == 0 || exp_ovr_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_underflow: consumed word 0x%0h, expected none pending", data);
      end else begin
        checkw("sb_data", data, exp_data_q.pop_front());
        check1("sb_overrun", overrun, exp_ovr_q.pop_front());
      end
    end
    if (!rst && frame_err === 1'b1) fe_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int fe_at;
    int fe_cnt;
    logic bad;
    logic [W-1:0] w;

    // Reset values
    tick(3);
    checkw("rst_data", data, '0);
    check1("rst_valid", valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_overrun", overrun, 1'b0);
    check1("rst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    tick(4);

    // Basic word with exact latency, then ack
    send_frame(8'hA5, 1'b0, M_LAT);
    do_ack();
    check1("ack_drops_valid", valid, 1'b0);

    // Overrun: second frame dropped, first word kept
    send_frame(8'h3C, 1'b0, M_PLAIN);
    send_frame(8'hF0, 1'b0, M_PLAIN);
    tick(2);
    checkw("overrun_keeps_data", data, 8'h3C);
    check1("overrun_set", overrun, 1'b1);
    do_ack();
    check1("overrun_ack_valid", valid, 1'b0);
    check1("overrun_cleared", overrun, 1'b0);

    // Ack exactly in DONE of the second frame
    send_frame(8'h11, 1'b0, M_PLAIN);
    send_frame(8'h22, 1'b0, M_ACKDONE);
    do_ack();

    // Timeout after three bits
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check1("busy_partial", busy, 1'b1);
    fe_exp++;
    fe_at  = -1;
    fe_cnt = 0;
    for (int j = 5; j <= TO + 10; j++) begin
      tick(1);
      if (frame_err === 1'b1) begin
        fe_cnt++;
        if (fe_at < 0) fe_at = j;
      end
    end
    checki("timeout_cycle", fe_at, TO + 3);
    checki("timeout_pulse_len", fe_cnt, 1);
    check1("timeout_busy", busy, 1'b0);
    check1("timeout_valid", valid, 1'b0);
    send_frame(8'h81, 1'b0, M_LAT);
    do_ack();

    // Reset in the middle of a frame
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    check1("rst_mid_busy", busy, 1'b0);
    send_frame(8'h7E, 1'b0, M_LAT);
    do_ack();

`ifdef SERIAL_RX_PARITY_EN
    send_frame(8'h07, 1'b0, M_LAT);
    do_ack();
    send_frame(8'h07, 1'b1, M_LAT);
    check1("parity_bad_valid", valid, 1'b0);
`endif

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 5) begin
        w   = W'($urandom);
        bad = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        bad = ($urandom_range(0, 7) == 0);
`endif
        send_frame(w, bad, M_PLAIN);
      end else if (r <= 7) begin
        do_ack();
      end else if (r == 8) begin
        int k;
        k = int'($urandom_range(1, NB - 1));
        for (int i = 0; i < k; i++) send_bit(1'($urandom));
        tick(TO + 8);
        fe_exp++;
      end else begin
        tick(int'($urandom_range(0, 20)));
        if (!m_valid) do_ack();
      end
      tick(2);
      check_model("rand");
    end

    if (m_valid) do_ack();
    tick(3);
    check_model("final");
    checki("frame_err_count", fe_seen, fe_exp);
    checki("sb_data_left", exp_data_q.size(), 0);
    checki("sb_ovr_left", exp_ovr_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
